// File: rtl/z80_bus_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : z80_bus_arbiter
// Brief   : Round-robin arbiter granting the Z80 bus to one of two external
//           masters via nBUSRQ/nBUSACK. Optional grant watchdog enabled by
//           defining Z80_BUSARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module z80_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic       nBUSACK,
    output logic       nBUSRQ,
    output logic [1:0] gnt,
    output logic       owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
        $error("z80_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_t     r_state;
    logic       r_nBusRq;
    logic [1:0] r_gnt;
    logic       r_owner;
    logic       r_lastGranted;
    logic       r_busy;
    logic       w_sel;
    logic [1:0] w_ownerOneHot;

    // A tie goes to whichever master did not win the previous grant.
    always_comb begin
        w_sel = ~r_lastGranted;
        case (req)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            default: w_sel = ~r_lastGranted;
        endcase
    end

    assign w_ownerOneHot = r_owner ? 2'b10 : 2'b01;

`ifdef Z80_BUSARB_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_timeoutCnt;
    logic        r_timeout;
`endif

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state       <= S_IDLE;
            r_nBusRq      <= 1'b1;
            r_gnt         <= 2'b00;
            r_owner       <= 1'b0;
            r_lastGranted <= 1'b1;
            r_busy        <= 1'b0;
`ifdef Z80_BUSARB_TIMEOUT_EN
            r_timeoutCnt  <= 16'd0;
            r_timeout     <= 1'b0;
`endif
        end else begin
`ifdef Z80_BUSARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_gnt    <= 2'b00;
                    r_nBusRq <= 1'b1;
                    r_busy   <= 1'b0;
                    if (|req) begin
                        r_owner  <= w_sel;
                        r_state  <= S_REQ;
                        r_nBusRq <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                // A withdrawn request still waits for BUSACK so the Z80
                // finishes its current bus cycle before we let go.
                S_REQ: begin
                    if (!nBUSACK) begin
                        if (req[r_owner]) begin
                            r_state       <= S_GRANT;
                            r_gnt         <= w_ownerOneHot;
                            r_lastGranted <= r_owner;
`ifdef Z80_BUSARB_TIMEOUT_EN
                            r_timeoutCnt  <= 16'd0;
`endif
                        end else begin
                            r_state  <= S_RELEASE;
                            r_nBusRq <= 1'b1;
                        end
                    end
                end
                S_GRANT: begin
                    if (done[r_owner] || !req[r_owner] || nBUSACK) begin
                        r_state  <= S_RELEASE;
                        r_gnt    <= 2'b00;
                        r_nBusRq <= 1'b1;
                    end
`ifdef Z80_BUSARB_TIMEOUT_EN
                    else if (r_timeoutCnt == c_TIMEOUT_LAST) begin
                        r_state   <= S_RELEASE;
                        r_gnt     <= 2'b00;
                        r_nBusRq  <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + 16'd1;
                    end
`endif
                end
                S_RELEASE: begin
                    r_gnt    <= 2'b00;
                    r_nBusRq <= 1'b1;
                    if (nBUSACK) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_gnt    <= 2'b00;
                    r_nBusRq <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign nBUSRQ = r_nBusRq;
    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign busy   = r_busy;
`ifdef Z80_BUSARB_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_z80_bus_arbiter
// Brief   : Self-checking bench for z80_bus_arbiter; per-cycle expectations are
//           queued with the stimulus and checked after the following edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_z80_bus_arbiter;

    localparam int c_TIMEOUT = 8;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] done = 2'b00;
    logic       nBUSACK = 1'b1;
    logic       nBUSRQ;
    logic [1:0] gnt;
    logic       owner;
    logic       busy;
    logic       timeout;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        string      tag;
        logic       nb;
        logic [1:0] g;
        logic       ow;
        logic       bz;
        logic       to;
    } exp_t;

    exp_t sb[$];

    z80_bus_arbiter #(.TIMEOUT_CYCLES(c_TIMEOUT)) u_dut (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .req     (req),
        .done    (done),
        .nBUSACK (nBUSACK),
        .nBUSRQ  (nBUSRQ),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs === expv) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the next edge.
    task automatic step(input string tag, input logic rn, input logic [1:0] r, input logic [1:0] d,
                        input logic ack, input logic enb, input logic [1:0] eg, input logic eow,
                        input logic ebz, input logic eto);
        exp_t e;
        exp_t o;
        @(negedge CLK);
        nRESET = rn; req = r; done = d; nBUSACK = ack;
        e.tag = tag; e.nb = enb; e.g = eg; e.ow = eow; e.bz = ebz; e.to = eto;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        o = sb.pop_front();
        chk({o.tag, ".nBUSRQ"},  {31'd0, nBUSRQ},  {31'd0, o.nb});
        chk({o.tag, ".gnt"},     {30'd0, gnt},     {30'd0, o.g});
        chk({o.tag, ".owner"},   {31'd0, owner},   {31'd0, o.ow});
        chk({o.tag, ".busy"},    {31'd0, busy},    {31'd0, o.bz});
        chk({o.tag, ".timeout"}, {31'd0, timeout}, {31'd0, o.to});
        chk({o.tag, ".onehot"},  {31'd0, ($countones(gnt) <= 1)}, 32'd1);
        if (ack && rn) chk({o.tag, ".gntAfterAck1"}, {30'd0, gnt}, 32'd0);
    endtask

    task automatic doReset();
        step("rst0", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic xact(input string tag, input logic [1:0] r, input logic eo);
        logic [1:0] oh;
        oh = eo ? 2'b10 : 2'b01;
        step({tag, ".req"},  1'b1, r, 2'b00, 1'b1, 1'b0, 2'b00, eo, 1'b1, 1'b0);
        step({tag, ".gnt"},  1'b1, r, 2'b00, 1'b0, 1'b0, oh,    eo, 1'b1, 1'b0);
        step({tag, ".done"}, 1'b1, r, oh,    1'b0, 1'b1, 2'b00, eo, 1'b1, 1'b0);
        step({tag, ".idle"}, 1'b1, r, 2'b00, 1'b1, 1'b1, 2'b00, eo, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        doReset();

        // Single request, cycle-accurate latencies
        step("s.c0", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++)
            step("s.wait", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("s.c4", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        for (int i = 5; i <= 8; i++)
            step("s.hold", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        step("s.c9", 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 10; i <= 11; i++)
            step("s.rel", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        step("s.c12", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

        // Tie fairness from reset: 0,1,0 then single request for master 1
        doReset();
        xact("tie1", 2'b11, 1'b0);
        xact("tie2", 2'b11, 1'b1);
        xact("tie3", 2'b11, 1'b0);
        xact("single1", 2'b10, 1'b1);

        // Withdrawal before BUSACK: nBUSRQ held until BUSACK, no grant
        doReset();
        step("w.req", 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        step("w.wd0", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        step("w.wd1", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        step("w.ack", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        step("w.idle", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);

        // Long grant; non-owner done/req activity must be ignored
        doReset();
        step("to.req", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("to.gnt", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
`ifdef Z80_BUSARB_TIMEOUT_EN
        for (int i = 1; i < c_TIMEOUT; i++)
            step("to.hold", 1'b1, {i[0], 1'b1}, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        step("to.expire", 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        step("to.pulse1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        step("to.idle", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        // done coinciding with expiry wins: no timeout pulse
        step("tp.req", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("tp.gnt", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < c_TIMEOUT; i++)
            step("tp.hold", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        step("tp.done", 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        step("tp.idle", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
`else
        for (int i = 1; i <= 100; i++)
            step("to.hold", 1'b1, {i[0], 1'b1}, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        step("to.done", 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        step("to.idle", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
`endif

        // BUSACK rising during grant drops gnt at once
        doReset();
        step("pv.req", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("pv.gnt", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        step("pv.ack1", 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        step("pv.idle", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-grant
        doReset();
        step("rm.req", 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        step("rm.gnt", 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        step("rm.hold", 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        step("rm.rst", 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step("rm.after", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z80_bus_arbiter.md
Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the number of grant cycles before forced release (used only when Z80_BUSARB_TIMEOUT_EN is defined); legal range 2..65535.
REQ-002 Ports SHALL be, one per line, all synchronous to CLK; one clock, reset synchronous and active-low:
- CLK  input  1  system clock, all state updates on rising edge
- nRESET  input  1  synchronous active-low reset
- req  input  2  bus requests from external masters 0 and 1, active-high level
- done  input  2  one-cycle release pulse from the current owner
- nBUSACK  input  1  Z80 bus acknowledge, active-low
- nBUSRQ  output  1  Z80 bus request, active-low, registered
- gnt  output  2  one-hot grant to master 0/1, registered
- owner  output  1  index of last/current granted master
- busy  output  1  high in any state other than IDLE
- timeout  output  1  one-cycle pulse on forced release

Function
REQ-003 FSM states SHALL be IDLE, REQ, GRANT, RELEASE.
REQ-004 IDLE: nBUSRQ=1, gnt=00; if any req bit is high, latch the selected master into owner, go to REQ, and drive nBUSRQ=0 on the next cycle (1-cycle latency).
REQ-005 Selection SHALL be round-robin: if only one req bit is high, that master wins; if both are high, the master != last-granted wins; last-granted resets to 1, so master 0 wins the first tie.
REQ-006 REQ: nBUSRQ held 0; when nBUSACK is sampled 0 and req[owner]=1, go to GRANT and assert gnt[owner] the next cycle.
REQ-007 REQ: if nBUSACK is sampled 0 while req[owner]=0 (request withdrawn), go directly to RELEASE without asserting gnt.
REQ-008 REQ: a req withdrawal while nBUSACK=1 SHALL NOT deassert nBUSRQ; the Z80 bus cycle is completed before release.
REQ-009 GRANT: gnt[owner]=1 and nBUSRQ=0 until done[owner]=1 or req[owner]=0; then gnt=00 and nBUSRQ=1 on the next cycle, state RELEASE.
REQ-010 done or req changes of the non-owner SHALL be ignored in REQ and GRANT.
REQ-011 GRANT: if nBUSACK rises (protocol violation), gnt SHALL drop next cycle and state SHALL go to RELEASE.
REQ-012 RELEASE: nBUSRQ=1, gnt=00; return to IDLE only after nBUSACK is sampled 1; a new grant is therefore never issued earlier than 2 cycles after release.
REQ-013 At most one gnt bit SHALL ever be high; gnt SHALL never be high while nBUSACK was sampled 1 in the previous cycle.
REQ-014 last-granted SHALL update to owner on entry to GRANT only.
REQ-015 busy SHALL equal (state != IDLE), registered.

Reset
REQ-016 While nRESET=0 at a CLK edge: state=IDLE, nBUSRQ=1, gnt=00, owner=0, last-granted=1, busy=0, timeout=0, timeout counter=0.
REQ-017 Reset asserted mid-GRANT SHALL drop gnt and deassert nBUSRQ on the first edge with nRESET=0, with no timeout pulse.

Configuration
REQ-018 With Z80_BUSARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on GRANT entry and increment each GRANT cycle; when it reaches TIMEOUT_CYCLES-1 without done, gnt drops next cycle, timeout pulses for exactly one cycle, and state goes to RELEASE; done in the same cycle as expiry SHALL take precedence (no timeout pulse).
REQ-019 Without Z80_BUSARB_TIMEOUT_EN: no counter SHALL be instantiated, timeout is tied 0, and a grant lasts indefinitely.

Verification
REQ-020 Single request: req=01 at cycle 0 -> nBUSRQ=0 at cycle 1; nBUSACK=0 at cycle 4 -> gnt=01 at cycle 5; done=01 at cycle 9 -> gnt=00, nBUSRQ=1 at cycle 10; nBUSACK=1 at cycle 12 -> busy=0 at cycle 13.
REQ-021 Tie fairness: req=11 held for three back-to-back transactions from reset -> grant order 0,1,0; never gnt=11.
REQ-022 Withdrawal: req=10, then req=00 before nBUSACK falls -> nBUSRQ stays 0 until nBUSACK=0, then goes 1 with gnt never asserted.
REQ-023 Timeout (macro on, TIMEOUT_CYCLES=8): grant with no done -> gnt high for exactly 8 cycles, timeout=1 for one cycle, then RELEASE; macro off -> gnt held for 100 cycles, timeout stays 0.
REQ-024 Reset mid-grant: nRESET=0 during GRANT -> next edge gnt=00, nBUSRQ=1, owner=0, busy=0, timeout=0.
